// File: rtl/mesh_router_grid.sv
// mesh_router_grid: switch among 2*(ROWS+COLUMS) mesh edge terminals, one move per cycle.
// Optional broadcast is enabled by defining MESH_BCAST_EN.

// mesh_fifo: generic show-ahead FIFO with synchronous active-high reset.
// Latency: a push at edge k is visible on head_dat/empty after edge k.
// Backpressure: push while full and pop while empty are ignored; push is not helped by a same-cycle pop.
module mesh_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// mesh_router_grid: endpoint-equivalent ROWS x COLUMS mesh switch with per-terminal in/out FIFOs.
// Latency: packet captured at edge k shows on pndng/data_out after edge k+1.
// Backpressure: popin drops on a full input FIFO; a full output FIFO stalls only inputs that target it.
module mesh_router_grid #(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF,
    localparam int        N          = 2 * (ROWS + COLUMS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0][pckg_sz-1:0] data_out_i_in,
    input  logic [N-1:0]              pndng_i_in,
    output logic [N-1:0]              popin,
    output logic [N-1:0][pckg_sz-1:0] data_out,
    output logic [N-1:0]              pndng,
    input  logic [N-1:0]              pop
);
    localparam int PW = $clog2(N);

    logic [N-1:0]              in_full;
    logic [N-1:0]              in_empty;
    logic [N-1:0]              in_pop;
    logic [N-1:0]              out_full;
    logic [N-1:0]              out_empty;
    logic [N-1:0]              out_push;
    logic [N-1:0][pckg_sz-1:0] in_head;
    logic [N-1:0][pckg_sz-1:0] out_head;
    logic [N-1:0][N-1:0]       need;
    logic [N-1:0]              is_bcast;
    logic [N-1:0]              eligible;
    logic [pckg_sz-1:0]        move_dat;
    logic [PW-1:0]             ptr;
    logic [PW-1:0]             win;
    logic [PW-1:0]             win_hi;
    logic [PW-1:0]             win_lo;
    logic                      found;
    logic                      found_hi;
    logic                      found_lo;

    // Edge coordinates -> one-hot terminal; corners and out-of-range coordinates give an empty mask.
    function automatic logic [N-1:0] route_mask(input logic [3:0] row, input logic [3:0] col);
        logic [N-1:0] m;
        int           r;
        int           c;
        int           idx;
        r   = int'(row);
        c   = int'(col);
        idx = -1;
        if (r == 0 && c >= 1 && c <= COLUMS)                idx = c - 1;
        else if (c == 0 && r >= 1 && r <= ROWS)             idx = COLUMS + r - 1;
        else if (r == ROWS + 1 && c >= 1 && c <= COLUMS)    idx = COLUMS + ROWS + c - 1;
        else if (c == COLUMS + 1 && r >= 1 && r <= ROWS)    idx = 2 * COLUMS + ROWS + r - 1;
        for (int t = 0; t < N; t++) m[t] = (t == idx);
        return m;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            is_bcast[i] = 1'b0;
`ifdef MESH_BCAST_EN
            is_bcast[i] = (in_head[i][pckg_sz-1 -: 8] == bdcst);
`endif
            if (is_bcast[i]) need[i] = ~(N'(1) << i);
            else             need[i] = route_mask(in_head[i][pckg_sz-9 -: 4], in_head[i][pckg_sz-13 -: 4]);
            eligible[i] = ~in_empty[i] & ~|(need[i] & out_full);
        end
    end

    // Round-robin: first eligible at or above ptr wins, otherwise first eligible below ptr.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                if (PW'(i) >= ptr) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        win_hi   = PW'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = PW'(i);
                end
            end
        end
        found = found_hi | found_lo;
        win   = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        in_pop   = '0;
        out_push = '0;
        move_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (found && win == PW'(i)) begin
                in_pop[i] = 1'b1;
                out_push  = need[i];
                move_dat  = in_head[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      ptr <= '0;
        else if (found) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end

    for (genvar g = 0; g < N; g++) begin : g_term
        mesh_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_in (
            .clk      (clk),
            .reset    (reset),
            .push     (popin[g]),
            .push_dat (data_out_i_in[g]),
            .pop      (in_pop[g]),
            .head_dat (in_head[g]),
            .full     (in_full[g]),
            .empty    (in_empty[g])
        );

        mesh_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_out (
            .clk      (clk),
            .reset    (reset),
            .push     (out_push[g]),
            .push_dat (move_dat),
            .pop      (pop[g]),
            .head_dat (out_head[g]),
            .full     (out_full[g]),
            .empty    (out_empty[g])
        );

        assign popin[g]    = pndng_i_in[g] & ~in_full[g] & ~reset;
        assign pndng[g]    = ~out_empty[g];
        assign data_out[g] = out_empty[g] ? '0 : out_head[g];
    end
endmodule

// File: tb/tb_mesh_router_grid.sv
// Randomized traffic against a queue-level reference of the mesh switch (4x4, 16 terminals).
module tb_mesh_router_grid;
    localparam int         R  = 4;
    localparam int         C  = 4;
    localparam int         N  = 2 * (R + C);
    localparam int         PW = 40;
    localparam int         D  = 4;
    localparam logic [7:0] BC = 8'hFF;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0][PW-1:0] data_out_i_in;
    logic [N-1:0]         pndng_i_in;
    logic [N-1:0]         popin;
    logic [N-1:0][PW-1:0] data_out;
    logic [N-1:0]         pndng;
    logic [N-1:0]         pop;

    always #5 clk = ~clk;

    mesh_router_grid #(
        .ROWS(R), .COLUMS(C), .pckg_sz(PW), .fifo_depth(D), .bdcst(BC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .data_out      (data_out),
        .pndng         (pndng),
        .pop           (pop)
    );

    int compared   = 0;
    int mismatched = 0;

    int            term_row [N];
    int            term_col [N];
    logic [PW-1:0] in_q  [N][D];
    logic [PW-1:0] out_q [N][D];
    int            in_n  [N];
    int            out_n [N];
    int            m_ptr;
    logic [N-1:0]  exp_popin;
    logic [N-1:0]  taken;
    bit            was_reset;

    bit src_en [N];
    bit pop_en [N];
    bit hot    [N];
    int offer_pct, pop_pct, hot_dest, bad_pct, bc_pct, rst_pct;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Destination set: search the terminal coordinate table; broadcast goes everywhere but home.
    function automatic logic [N-1:0] targets(input logic [PW-1:0] p, input int src);
        logic [N-1:0] m;
        bit           is_bc;
        is_bc = 1'b0;
`ifdef MESH_BCAST_EN
        is_bc = (p[PW-1 -: 8] == BC);
`endif
        m = '0;
        for (int t = 0; t < N; t++) begin
            if (is_bc) m[t] = (t != src);
            else m[t] = (term_row[t] == int'(p[PW-9 -: 4])) && (term_col[t] == int'(p[PW-13 -: 4]));
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] gen_pkt(input int src);
        logic [PW-1:0] p;
        int            d;
        p = PW'({$urandom, $urandom});
        p[PW-1 -: 8] = (int'($urandom_range(0, 99)) < bc_pct) ? BC : 8'($urandom_range(0, 254));
        if (int'($urandom_range(0, 99)) < bad_pct) begin
            p[PW-9 -: 4]  = 4'($urandom_range(R + 2, 15));
            p[PW-13 -: 4] = 4'($urandom_range(0, 15));
        end else begin
            d = hot[src] ? hot_dest : int'($urandom_range(0, N - 1));
            p[PW-9 -: 4]  = 4'(term_row[d]);
            p[PW-13 -: 4] = 4'(term_col[d]);
        end
        return p;
    endfunction

    task automatic model_step();
        logic [N-1:0]  need;
        logic [N-1:0]  win_need;
        logic [PW-1:0] pkt;
        int            win;
        int            s;
        bit            ok;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                in_n[i]  = 0;
                out_n[i] = 0;
            end
            m_ptr = 0;
            return;
        end
        win      = -1;
        win_need = '0;
        for (int k = 0; k < N; k++) begin
            s = (m_ptr + k) % N;
            if (win < 0 && in_n[s] > 0) begin
                need = targets(in_q[s][0], s);
                ok   = 1'b1;
                for (int t = 0; t < N; t++) if (need[t] && out_n[t] >= D) ok = 1'b0;
                if (ok) begin
                    win      = s;
                    win_need = need;
                end
            end
        end
        for (int t = 0; t < N; t++) begin
            if (pop[t] && out_n[t] > 0) begin
                for (int j = 0; j < D - 1; j++) out_q[t][j] = out_q[t][j+1];
                out_n[t]--;
            end
        end
        if (win >= 0) begin
            pkt = in_q[win][0];
            for (int j = 0; j < D - 1; j++) in_q[win][j] = in_q[win][j+1];
            in_n[win]--;
            for (int t = 0; t < N; t++) begin
                if (win_need[t]) begin
                    out_q[t][out_n[t]] = pkt;
                    out_n[t]++;
                end
            end
            m_ptr = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (exp_popin[i]) begin
                in_q[i][in_n[i]] = data_out_i_in[i];
                in_n[i]++;
            end
        end
    endtask

    // One clock: drive devices at the falling edge, check outputs, advance the model past the next rising edge.
    task automatic step_cycle();
        logic [N-1:0] exp_pndng;
        for (int i = 0; i < N; i++) begin
            if (taken[i]) pndng_i_in[i] = 1'b0;
            if (!pndng_i_in[i] && src_en[i] && int'($urandom_range(0, 99)) < offer_pct) begin
                data_out_i_in[i] = gen_pkt(i);
                pndng_i_in[i]    = 1'b1;
            end
            pop[i] = pop_en[i] && (int'($urandom_range(0, 99)) < pop_pct);
        end
        reset = (int'($urandom_range(0, 99)) < rst_pct);
        #1;
        for (int i = 0; i < N; i++) begin
            exp_popin[i] = pndng_i_in[i] && (in_n[i] < D) && !reset;
            exp_pndng[i] = (out_n[i] > 0);
        end
        chk("popin", 64'(popin), 64'(exp_popin));
        chk("pndng", 64'(pndng), 64'(exp_pndng));
        for (int t = 0; t < N; t++) begin
            if (out_n[t] > 0) chk($sformatf("data_out%0d", t), 64'(data_out[t]), 64'(out_q[t][0]));
            else if (was_reset) chk($sformatf("rst_data_out%0d", t), 64'(data_out[t]), 64'd0);
        end
        taken     = exp_popin;
        was_reset = reset;
        model_step();
        @(negedge clk);
    endtask

    task automatic shape(input int src_lo, input int src_hi, input int offer, input int popp, input int hot_lo,
                         input int hot_hi, input int hdest, input int bad, input int bc, input int rst);
        for (int i = 0; i < N; i++) begin
            src_en[i] = (i >= src_lo && i <= src_hi);
            hot[i]    = (i >= hot_lo && i <= hot_hi);
            pop_en[i] = 1'b1;
        end
        offer_pct = offer;
        pop_pct   = popp;
        hot_dest  = hdest;
        bad_pct   = bad;
        bc_pct    = bc;
        rst_pct   = rst;
    endtask

    initial begin
        for (int t = 0; t < N; t++) begin
            if (t < C)              begin term_row[t] = 0;               term_col[t] = t + 1;         end
            else if (t < C + R)     begin term_row[t] = t - C + 1;       term_col[t] = 0;             end
            else if (t < 2 * C + R) begin term_row[t] = R + 1;           term_col[t] = t - C - R + 1; end
            else                    begin term_row[t] = t - 2 * C - R + 1; term_col[t] = C + 1;       end
            in_n[t]  = 0;
            out_n[t] = 0;
        end
        m_ptr         = 0;
        reset         = 1'b1;
        pndng_i_in    = '0;
        pop           = '0;
        data_out_i_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pndng", 64'(pndng), 64'd0);
        chk("rst_popin", 64'(popin), 64'd0);
        was_reset = 1'b1;
        taken     = '0;

        // Lone unicasts from terminal 0 to terminal 5
        shape(0, 0, 10, 100, 0, 0, 5, 0, 0, 0);
        repeat (60) step_cycle();
        // General mixed traffic
        shape(0, N - 1, 40, 70, -1, -1, 0, 5, 5, 0);
        repeat (500) step_cycle();
        // Terminals 0..3 flood terminal 5 while it is not popped; others keep moving
        shape(0, N - 1, 100, 80, 0, 3, 5, 0, 0, 0);
        for (int i = 4; i < N; i++) src_en[i] = ($urandom_range(0, 1) == 1);
        pop_en[5] = 1'b0;
        repeat (80) step_cycle();
        pop_en[5] = 1'b1;
        pop_pct   = 100;
        repeat (120) step_cycle();
        // Terminals 0,1,2 compete for terminal 9
        shape(0, 2, 100, 50, 0, 2, 9, 0, 0, 0);
        repeat (200) step_cycle();
        // Broadcast-heavy traffic
        shape(0, N - 1, 30, 60, -1, -1, 0, 5, 50, 0);
        repeat (300) step_cycle();
        // Mostly unroutable addresses
        shape(0, N - 1, 50, 70, -1, -1, 0, 60, 0, 0);
        repeat (200) step_cycle();
        // Traffic with occasional resets
        shape(0, N - 1, 50, 50, -1, -1, 0, 5, 10, 3);
        repeat (600) step_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
